// File: rtl/axis_pkg.sv
// axis_pkg: shared helpers for the AXI4-Stream FIFO, packed word sizing and disabled-field defaults.
package axis_pkg;

    localparam logic DEF_LAST = 1'b1;
    localparam logic DEF_KEEP = 1'b1;
    localparam logic DEF_SIDE = 1'b0;

    function automatic int word_width(
        input int dw,
        input int ke,
        input int kw,
        input int le,
        input int ie,
        input int iw,
        input int de,
        input int dsw,
        input int ue,
        input int uw
    );
        return dw + (ke != 0 ? kw : 0) + (le != 0 ? 1 : 0) + (ie != 0 ? iw : 0)
            + (de != 0 ? dsw : 0) + (ue != 0 ? uw : 0);
    endfunction

endpackage

// File: rtl/axis_fifo_ram.sv
// axis_fifo_ram: simple dual-port RAM, one write port and one synchronous read port, storage not reset.
module axis_fifo_ram #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 16
) (
    input  logic                     clk,
    input  logic                     wr_en,
    input  logic [$clog2(DEPTH)-1:0] wr_addr,
    input  logic [WIDTH-1:0]         wr_data,
    input  logic                     rd_en,
    input  logic [$clog2(DEPTH)-1:0] rd_addr,
    output logic [WIDTH-1:0]         rd_data
);

    logic [WIDTH-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (wr_en) mem[wr_addr] <= wr_data;
        if (rd_en) rd_data <= mem[rd_addr];
    end

endmodule

// File: rtl/axis_fifo.sv
// axis_fifo: single-clock AXI4-Stream FIFO, DEPTH beats of RAM plus one registered output beat.
module axis_fifo
    import axis_pkg::*;
#(
    parameter int DATA_WIDTH  = 8,
    parameter int KEEP_ENABLE = (DATA_WIDTH > 8),
    parameter int KEEP_WIDTH  = (DATA_WIDTH + 7) / 8,
    parameter int LAST_ENABLE = 0,
    parameter int ID_ENABLE   = 0,
    parameter int ID_WIDTH    = 8,
    parameter int DEST_ENABLE = 0,
    parameter int DEST_WIDTH  = 8,
    parameter int USER_ENABLE = 0,
    parameter int USER_WIDTH  = 1,
    parameter int DEPTH       = 16
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [DATA_WIDTH-1:0]      s_axis_tdata,
    input  logic                       s_axis_tvalid,
    output logic                       s_axis_tready,
    input  logic                       s_axis_tlast,
    input  logic [KEEP_WIDTH-1:0]      s_axis_tkeep,
    input  logic [USER_WIDTH-1:0]      s_axis_tuser,
    input  logic [ID_WIDTH-1:0]        s_axis_tid,
    input  logic [DEST_WIDTH-1:0]      s_axis_tdest,
    output logic [DATA_WIDTH-1:0]      m_axis_tdata,
    output logic                       m_axis_tvalid,
    input  logic                       m_axis_tready,
    output logic                       m_axis_tlast,
    output logic [KEEP_WIDTH-1:0]      m_axis_tkeep,
    output logic [USER_WIDTH-1:0]      m_axis_tuser,
    output logic [ID_WIDTH-1:0]        m_axis_tid,
    output logic [DEST_WIDTH-1:0]      m_axis_tdest,
    output logic [$clog2(DEPTH):0]     status_count,
    output logic                       status_full,
    output logic                       status_empty
);

    localparam int AW  = $clog2(DEPTH);
    localparam int CW  = AW + 1;
    localparam int UO  = 0;
    localparam int DSO = UO + (USER_ENABLE != 0 ? USER_WIDTH : 0);
    localparam int IO  = DSO + (DEST_ENABLE != 0 ? DEST_WIDTH : 0);
    localparam int LO  = IO + (ID_ENABLE != 0 ? ID_WIDTH : 0);
    localparam int KO  = LO + (LAST_ENABLE != 0 ? 1 : 0);
    localparam int TO  = KO + (KEEP_ENABLE != 0 ? KEEP_WIDTH : 0);
    localparam int W   = word_width(DATA_WIDTH, KEEP_ENABLE, KEEP_WIDTH, LAST_ENABLE, ID_ENABLE,
                                    ID_WIDTH, DEST_ENABLE, DEST_WIDTH, USER_ENABLE, USER_WIDTH);

    logic [W-1:0]          wr_word;
    logic [W-1:0]          rd_word;
    logic [DATA_WIDTH-1:0] r_data;
    logic [KEEP_WIDTH-1:0] r_keep;
    logic                  r_last;
    logic [ID_WIDTH-1:0]   r_id;
    logic [DEST_WIDTH-1:0] r_dest;
    logic [USER_WIDTH-1:0] r_user;
    logic [AW:0]           wr_ptr;
    logic [AW:0]           rd_ptr;
    logic [AW:0]           fetch_ptr;
    logic                  s1_valid;
    logic                  full;
    logic                  push;
    logic                  out_hs;
    logic                  move;
    logic                  issue;
    logic                  unused_side;

    assign unused_side = ^{s_axis_tkeep, s_axis_tlast, s_axis_tid, s_axis_tdest, s_axis_tuser};

    assign wr_word[TO +: DATA_WIDTH] = s_axis_tdata;
    assign r_data = rd_word[TO +: DATA_WIDTH];

    generate
        if (KEEP_ENABLE != 0) begin : g_keep
            assign wr_word[KO +: KEEP_WIDTH] = s_axis_tkeep;
            assign r_keep = rd_word[KO +: KEEP_WIDTH];
        end else begin : g_nokeep
            assign r_keep = {KEEP_WIDTH{DEF_KEEP}};
        end
        if (LAST_ENABLE != 0) begin : g_last
            assign wr_word[LO] = s_axis_tlast;
            assign r_last = rd_word[LO];
        end else begin : g_nolast
            assign r_last = DEF_LAST;
        end
        if (ID_ENABLE != 0) begin : g_id
            assign wr_word[IO +: ID_WIDTH] = s_axis_tid;
            assign r_id = rd_word[IO +: ID_WIDTH];
        end else begin : g_noid
            assign r_id = {ID_WIDTH{DEF_SIDE}};
        end
        if (DEST_ENABLE != 0) begin : g_dest
            assign wr_word[DSO +: DEST_WIDTH] = s_axis_tdest;
            assign r_dest = rd_word[DSO +: DEST_WIDTH];
        end else begin : g_nodest
            assign r_dest = {DEST_WIDTH{DEF_SIDE}};
        end
        if (USER_ENABLE != 0) begin : g_user
            assign wr_word[UO +: USER_WIDTH] = s_axis_tuser;
            assign r_user = rd_word[UO +: USER_WIDTH];
        end else begin : g_nouser
            assign r_user = {USER_WIDTH{DEF_SIDE}};
        end
    endgenerate

    // A beat sitting in the RAM read register still owns its RAM slot until it
    // moves to the output register, which caps total occupancy at DEPTH+1.
    always_comb begin
        full   = (wr_ptr == {~rd_ptr[AW], rd_ptr[AW-1:0]});
        push   = s_axis_tvalid && s_axis_tready;
        out_hs = m_axis_tvalid && m_axis_tready;
        move   = s1_valid && (!m_axis_tvalid || m_axis_tready);
        issue  = (fetch_ptr != wr_ptr) && (!s1_valid || move);
    end

    assign s_axis_tready = !full && !rst;
    assign status_full   = full;
    assign status_empty  = (status_count == '0);

    axis_fifo_ram #(
        .WIDTH(W),
        .DEPTH(DEPTH)
    ) u_ram (
        .clk    (clk),
        .wr_en  (push),
        .wr_addr(wr_ptr[AW-1:0]),
        .wr_data(wr_word),
        .rd_en  (issue),
        .rd_addr(fetch_ptr[AW-1:0]),
        .rd_data(rd_word)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr        <= '0;
            rd_ptr        <= '0;
            fetch_ptr     <= '0;
            s1_valid      <= 1'b0;
            status_count  <= '0;
            m_axis_tvalid <= 1'b0;
            m_axis_tdata  <= '0;
            m_axis_tlast  <= 1'b0;
            m_axis_tkeep  <= '0;
            m_axis_tid    <= '0;
            m_axis_tdest  <= '0;
            m_axis_tuser  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + CW'(1);
            if (issue) fetch_ptr <= fetch_ptr + CW'(1);
            s1_valid     <= issue || (s1_valid && !move);
            status_count <= status_count + CW'(push) - CW'(out_hs);
            if (move) begin
                rd_ptr        <= rd_ptr + CW'(1);
                m_axis_tvalid <= 1'b1;
                m_axis_tdata  <= r_data;
                m_axis_tlast  <= r_last;
                m_axis_tkeep  <= r_keep;
                m_axis_tid    <= r_id;
                m_axis_tdest  <= r_dest;
                m_axis_tuser  <= r_user;
            end else if (out_hs) begin
                m_axis_tvalid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_axis_fifo.sv
// tb_axis_fifo: directed and random scoreboard checks of axis_fifo, plus a default-parameter instance for disabled-field values.
module tb_axis_fifo;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [7:0] s_tdata = '0;
    logic       s_tvalid = 1'b0;
    logic       s_tlast = 1'b0;
    logic [0:0] s_tkeep = '0;
    logic [0:0] s_tuser = '0;
    logic [7:0] s_tid = '0;
    logic [7:0] s_tdest = '0;
    logic       m_tready = 1'b0;
    logic       m_tready2 = 1'b1;

    logic       s_tready, m_tvalid, m_tlast, full, empty;
    logic [7:0] m_tdata, m_tid, m_tdest;
    logic [0:0] m_tkeep, m_tuser;
    logic [4:0] count;

    logic       unused_s_tready2, m_tvalid2, m_tlast2, unused_full2, unused_empty2;
    logic [7:0] m_tdata2, m_tid2, unused_m_tdest2;
    logic [0:0] m_tkeep2, unused_m_tuser2;
    logic [4:0] unused_count2;

    int n_chk = 0;
    int n_pass = 0;
    int n_pop = 0;
    int sent = 0;
    int acc = 0;
    logic last_push = 1'b0;
    logic [16:0] sb[$];

    always #5 clk = ~clk;

    axis_fifo #(
        .DATA_WIDTH(8), .LAST_ENABLE(1), .ID_ENABLE(1), .ID_WIDTH(8), .DEPTH(16)
    ) u_dut (
        .clk(clk), .rst(rst),
        .s_axis_tdata(s_tdata), .s_axis_tvalid(s_tvalid), .s_axis_tready(s_tready),
        .s_axis_tlast(s_tlast), .s_axis_tkeep(s_tkeep), .s_axis_tuser(s_tuser),
        .s_axis_tid(s_tid), .s_axis_tdest(s_tdest),
        .m_axis_tdata(m_tdata), .m_axis_tvalid(m_tvalid), .m_axis_tready(m_tready),
        .m_axis_tlast(m_tlast), .m_axis_tkeep(m_tkeep), .m_axis_tuser(m_tuser),
        .m_axis_tid(m_tid), .m_axis_tdest(m_tdest),
        .status_count(count), .status_full(full), .status_empty(empty)
    );

    axis_fifo u_dut2 (
        .clk(clk), .rst(rst),
        .s_axis_tdata(s_tdata), .s_axis_tvalid(s_tvalid), .s_axis_tready(unused_s_tready2),
        .s_axis_tlast(s_tlast), .s_axis_tkeep(s_tkeep), .s_axis_tuser(s_tuser),
        .s_axis_tid(s_tid), .s_axis_tdest(s_tdest),
        .m_axis_tdata(m_tdata2), .m_axis_tvalid(m_tvalid2), .m_axis_tready(m_tready2),
        .m_axis_tlast(m_tlast2), .m_axis_tkeep(m_tkeep2), .m_axis_tuser(unused_m_tuser2),
        .m_axis_tid(m_tid2), .m_axis_tdest(unused_m_tdest2),
        .status_count(unused_count2), .status_full(unused_full2), .status_empty(unused_empty2)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    endtask

    // Handshakes are judged mid-cycle, where inputs and registered outputs are stable.
    task automatic tick();
        logic [16:0] e;
        @(negedge clk);
        last_push = s_tvalid && s_tready;
        if (last_push) sb.push_back({s_tdata, s_tlast, s_tid});
        if (m_tvalid && m_tready) begin
            n_pop++;
            n_chk++;
            assert (sb.size() > 0) n_pass++;
            else $error("FAIL unexpected_beat: got %0h with nothing expected", m_tdata);
            if (sb.size() > 0) begin
                e = sb.pop_front();
                check("beat", {15'd0, m_tdata, m_tlast, m_tid}, {15'd0, e});
            end
        end
        if (m_tvalid2) check("dut2_defaults", {22'd0, m_tid2, m_tlast2, m_tkeep2}, {22'd0, 8'h00, 1'b1, 1'b1});
        @(posedge clk);
        #1;
    endtask

    initial begin
        repeat (2) tick();
        check("tready_in_reset", {31'd0, s_tready}, 32'd0);
        rst = 1'b0;
        #1;
        check("rel_tready", {31'd0, s_tready}, 32'd1);
        check("rel_empty", {31'd0, empty}, 32'd1);
        check("rel_full", {31'd0, full}, 32'd0);
        check("rel_tvalid", {31'd0, m_tvalid}, 32'd0);
        check("rel_outputs", {14'd0, m_tdata, m_tlast, m_tid, m_tkeep}, 32'd0);
        check("rel_count", {27'd0, count}, 32'd0);
        check("rel_dut2_outputs", {21'd0, m_tvalid2, m_tdata2, m_tlast2, m_tkeep2}, 32'd0);

        m_tready = 1'b1;
        s_tvalid = 1'b1; s_tdata = 8'hA5; s_tlast = 1'b1; s_tid = 8'h3C;
        tick();
        s_tvalid = 1'b0;
        check("lat_edge_n", {31'd0, m_tvalid}, 32'd0);
        tick();
        check("lat_edge_n1", {31'd0, m_tvalid}, 32'd0);
        tick();
        check("lat_edge_n2", {31'd0, m_tvalid}, 32'd1);
        check("lat_data", {24'd0, m_tdata}, 32'hA5);
        check("lat_count", {27'd0, count}, 32'd1);
        tick();
        check("single_count", {27'd0, count}, 32'd0);
        check("single_empty", {31'd0, empty}, 32'd1);

        n_pop = 0;
        for (int i = 0; i < 64; i++) begin
            s_tvalid = 1'b1; s_tdata = 8'(i); s_tlast = (i % 8 == 7); s_tid = 8'(i) ^ 8'h5A;
            check("stream_tready", {31'd0, s_tready}, 32'd1);
            tick();
        end
        s_tvalid = 1'b0;
        repeat (3) tick();
        check("stream_pops", n_pop, 32'd64);
        check("stream_tvalid", {31'd0, m_tvalid}, 32'd0);

        m_tready = 1'b0;
        acc = 0;
        for (int i = 0; i < 20; i++) begin
            s_tvalid = 1'b1; s_tdata = 8'h40 + 8'(i); s_tlast = i[0]; s_tid = 8'(i);
            tick();
            if (last_push) acc++;
        end
        s_tvalid = 1'b0;
        check("full_accepted", acc, 32'd17);
        check("full_count", {27'd0, count}, 32'd17);
        check("full_flag", {31'd0, full}, 32'd1);
        check("full_tready", {31'd0, s_tready}, 32'd0);
        check("full_head", {24'd0, m_tdata}, 32'h40);
        n_pop = 0;
        m_tready = 1'b1;
        tick();
        check("full_tready_after_pop", {31'd0, s_tready}, 32'd1);
        for (int c = 0; c < 40 && sb.size() > 0; c++) tick();
        repeat (2) tick();
        check("full_drain_pops", n_pop, 32'd17);
        check("full_drain_sb", sb.size(), 32'd0);
        check("full_drain_count", {27'd0, count}, 32'd0);

        n_pop = 0;
        sent = 0;
        last_push = 1'b0;
        s_tvalid = 1'b0;
        for (int c = 0; c < 20000 && (sent < 1000 || sb.size() > 0); c++) begin
            if (!s_tvalid || last_push) begin
                s_tvalid = (sent < 1000) && ($urandom_range(0, 1) == 1);
                s_tdata = 8'($urandom);
                s_tlast = 1'($urandom_range(0, 1));
                s_tid = 8'($urandom);
            end
            m_tready = 1'($urandom_range(0, 1));
            tick();
            if (last_push) sent++;
        end
        s_tvalid = 1'b0;
        check("rand_sent", sent, 32'd1000);
        check("rand_pops", n_pop, 32'd1000);
        check("rand_sb", sb.size(), 32'd0);
        check("rand_count", {27'd0, count}, 32'd0);

        m_tready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            s_tvalid = 1'b1; s_tdata = 8'hC0 + 8'(i); s_tlast = 1'b0; s_tid = 8'(i);
            tick();
        end
        s_tvalid = 1'b0;
        repeat (3) tick();
        check("pre_rst_count", {27'd0, count}, 32'd5);
        check("pre_rst_tvalid", {31'd0, m_tvalid}, 32'd1);
        rst = 1'b1;
        #1;
        check("rst_tvalid", {31'd0, m_tvalid}, 32'd0);
        check("rst_count", {27'd0, count}, 32'd0);
        check("rst_tready", {31'd0, s_tready}, 32'd0);
        check("rst_empty", {31'd0, empty}, 32'd1);
        sb.delete();
        tick();
        rst = 1'b0;
        m_tready = 1'b1;
        n_pop = 0;
        repeat (10) tick();
        check("post_rst_pops", n_pop, 32'd0);
        check("post_rst_tvalid", {31'd0, m_tvalid}, 32'd0);
        check("post_rst_empty", {31'd0, empty}, 32'd1);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
